ppg_beat_analyzer: RTL and testbench

Downstream stage of the controller/FIR top level. Consumes the two 20-bit filtered PPG streams (IR and RED) and detects heartbeats on the IR channel using a hysteresis peak/trough state machine. Per accepted beat it reports:
- the beat period in samples,
- the IR and RED peak-to-peak (AC) amplitudes,
- the IR and RED peak (DC-reference) levels.

Later SpO2 and heart-rate stages consume these values.

---
 rtl/ppg_pkg.sv | 6 +
 rtl/ppg_minmax_window.sv | 29 ++
 rtl/ppg_beat_analyzer.sv | 120 ++++++++++++
 tb/tb_ppg_beat_analyzer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// ppg_pkg: shared state encoding and default widths for the PPG beat pipeline
package ppg_pkg;
  localparam int DATA_W_DEF = 20;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
endpackage

// File: rtl/ppg_minmax_window.sv
// ppg_minmax_window: running max/min tracker with a synchronous reload
module ppg_minmax_window
  import ppg_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         update,
  input  logic [W-1:0] value,
  output logic [W-1:0] max_o,
  output logic [W-1:0] min_o
);
  logic [W-1:0] max_q, min_q;
  always_ff @(posedge clk)
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else if (load) begin
      max_q <= value;
      min_q <= value;
    end else if (update) begin
      max_q <= value > max_q ? value : max_q;
      min_q <= value < min_q ? value : min_q;
    end
  assign max_o = max_q;
  assign min_o = min_q;
endmodule

// File: rtl/ppg_beat_analyzer.sv
// ppg_beat_analyzer: IR hysteresis beat detector reporting period, AC and DC levels per beat
module ppg_beat_analyzer
  import ppg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int HYST       = 64,
  parameter int MIN_PERIOD = 40
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] ir_in,
  input  logic [DATA_W-1:0] red_in,
  output logic              beat_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] ac_ir,
  output logic [DATA_W-1:0] ac_red,
  output logic [DATA_W-1:0] dc_ir,
  output logic [DATA_W-1:0] dc_red,
  output logic              locked
);
  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  state_t state_q, state_d;
  logic [DATA_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d, trough_q, trough_d;
  logic [DATA_W-1:0] red_max, red_min, ac_ir_q, ac_red_q, dc_ir_q, dc_red_q;
  logic [CNT_W-1:0] since_q, since_d, sp_inc, period_q;
  logic first_q, first_d, beat_q, locked_q;
  logic sync_rst, peak, rise, accept, emit, red_load, red_upd;
  assign sync_rst = rst | clear;
  assign sp_inc = &since_q ? since_q : since_q + 1'b1;
  // Extra MSB keeps the hysteresis sums from wrapping near full scale
  assign peak = sample_valid && state_q == RISE && ({1'b0, ir_in} + HYST_X < {1'b0, run_max_q});
  assign rise = sample_valid && state_q == FALL && ({1'b0, ir_in} > {1'b0, run_min_q} + HYST_X);
  assign accept = peak && (first_q || sp_inc >= MIN_P);
  assign emit = accept && !first_q;
  assign red_load = sample_valid && (state_q == IDLE || accept);
  assign red_upd = sample_valid && !red_load;
  ppg_minmax_window #(.W(DATA_W)) u_red (
    .clk(CLK), .rst(sync_rst), .load(red_load), .update(red_upd),
    .value(red_in), .max_o(red_max), .min_o(red_min)
  );
  always_comb begin
    state_d = state_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    trough_d = trough_q;
    since_d = since_q;
    first_d = first_q;
    if (sample_valid) begin
      since_d = accept ? '0 : sp_inc;
      // A saturated counter means the period is unknown, so timing restarts at the next peak
      first_d = accept ? 1'b0 : (&sp_inc ? 1'b1 : first_q);
      case (state_q)
        IDLE: begin
          run_max_d = ir_in;
          run_min_d = ir_in;
          state_d = RISE;
        end
        RISE: begin
          run_max_d = ir_in > run_max_q ? ir_in : run_max_q;
          if (peak) begin
            run_min_d = ir_in;
            state_d = FALL;
          end
        end
        FALL: begin
          run_min_d = ir_in < run_min_q ? ir_in : run_min_q;
          if (rise) begin
            trough_d = run_min_q;
            run_max_d = ir_in;
            state_d = RISE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK)
    if (sync_rst) begin
      state_q <= IDLE;
      run_max_q <= '0;
      run_min_q <= '0;
      trough_q <= '0;
      since_q <= '0;
      first_q <= 1'b1;
      beat_q <= 1'b0;
      period_q <= '0;
      ac_ir_q <= '0;
      ac_red_q <= '0;
      dc_ir_q <= '0;
      dc_red_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      trough_q <= trough_d;
      since_q <= since_d;
      first_q <= first_d;
      beat_q <= emit;
      if (emit) begin
        period_q <= sp_inc;
        ac_ir_q <= run_max_q - trough_q;
        ac_red_q <= red_max - red_min;
        dc_ir_q <= run_max_q;
        dc_red_q <= red_max;
        locked_q <= 1'b1;
      end
    end
  assign beat_valid = beat_q;
  assign period = period_q;
  assign ac_ir = ac_ir_q;
  assign ac_red = ac_red_q;
  assign dc_ir = dc_ir_q;
  assign dc_red = dc_red_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_ppg_beat_analyzer.sv
// tb_ppg_beat_analyzer: directed waveforms with a scoreboard of expected beats
module tb_ppg_beat_analyzer;
  localparam int DW = 20;
  localparam int CW = 16;
  logic CLK = 1'b0, rst = 1'b1, clear = 1'b0, sample_valid = 1'b0;
  logic [DW-1:0] ir_in = '0, red_in = '0;
  logic beat_valid, locked;
  logic [CW-1:0] period;
  logic [DW-1:0] ac_ir, ac_red, dc_ir, dc_red;
  typedef struct packed {
    logic [CW-1:0] period;
    logic [DW-1:0] ac_ir, dc_ir, ac_red, dc_red;
  } beat_t;
  beat_t exp_q[$];
  beat_t e_b;
  int checks = 0, fails = 0, cur = 0, gap = 0;
  bit red_tri = 1'b0;

  ppg_beat_analyzer dut (
    .CLK(CLK), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .ir_in(ir_in), .red_in(red_in), .beat_valid(beat_valid), .period(period),
    .ac_ir(ac_ir), .ac_red(ac_red), .dc_ir(dc_ir), .dc_red(dc_red), .locked(locked)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int v);
    sample_valid = 1'b1;
    ir_in = DW'(v);
    red_in = red_tri ? DW'(200 + v * 2 / 5) : DW'(500);
    step();
    sample_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic seg(input int target);
    while (cur != target) begin
      cur += (target > cur) ? 20 : -20;
      drive(cur);
    end
  endtask

  task automatic push(input int p, input int a_ir, input int d_ir, input int a_red, input int d_red);
    exp_q.push_back('{CW'(p), DW'(a_ir), DW'(d_ir), DW'(a_red), DW'(d_red)});
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_beat_valid"}, beat_valid, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_ac_ir"}, ac_ir, 0);
    chk({tag, "_ac_red"}, ac_red, 0);
    chk({tag, "_dc_ir"}, dc_ir, 0);
    chk({tag, "_dc_red"}, dc_red, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic end_phase(input string tag);
    repeat (3) step();
    chk({tag, "_beats_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Clear lands together with a sample so clear priority is always exercised
  task automatic do_clear(input string tag);
    clear = 1'b1;
    sample_valid = 1'b1;
    ir_in = DW'(cur);
    step();
    clear = 1'b0;
    sample_valid = 1'b0;
    zero_outputs(tag);
    cur = 0;
  endtask

  always @(negedge CLK)
    if (beat_valid) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e_b = exp_q.pop_front();
        chk("period", period, e_b.period);
        chk("ac_ir", ac_ir, e_b.ac_ir);
        chk("dc_ir", dc_ir, e_b.dc_ir);
        chk("ac_red", ac_red, e_b.ac_red);
        chk("dc_red", dc_red, e_b.dc_red);
        chk("locked_with_beat", locked, 1);
      end
    end

  initial begin
    repeat (3) step();
    zero_outputs("reset");
    rst = 1'b0;
    gap = 1;
    drive(0);
    seg(1000);
    seg(0);
    chk("locked_before_first_beat", locked, 0);
    push(100, 1000, 1000, 0, 500);
    seg(1000);
    seg(0);
    push(100, 1000, 1000, 0, 500);
    seg(1000);
    seg(0);
    push(100, 1000, 1000, 0, 500);
    seg(1000);
    seg(900);
    end_phase("triangle");
    gap = 0;
    do_clear("clear_mid_fall");
    drive(0);
    seg(1000);
    seg(0);
    chk("locked_after_clear_first_peak", locked, 0);
    push(100, 1000, 1000, 0, 500);
    seg(1000);
    seg(900);
    end_phase("after_clear");
    do_clear("clear_noise");
    repeat (300) drive(770 + int'($urandom_range(0, 60)));
    chk("noise_locked", locked, 0);
    end_phase("noise");
    do_clear("clear_refractory");
    drive(0);
    seg(1000);
    seg(800);
    seg(1000);
    seg(200);
    push(100, 800, 1000, 0, 500);
    seg(1000);
    seg(900);
    end_phase("refractory");
    do_clear("clear_red");
    red_tri = 1'b1;
    drive(0);
    seg(1000);
    seg(0);
    push(100, 1000, 1000, 400, 600);
    seg(1000);
    seg(0);
    push(100, 1000, 1000, 400, 600);
    seg(1000);
    seg(900);
    end_phase("red_triangle");
    red_tri = 1'b0;
    do_clear("clear_saturation");
    drive(0);
    seg(1000);
    seg(0);
    repeat (70000) drive(0);
    seg(1000);
    seg(0);
    chk("saturation_no_beat_locked", locked, 0);
    push(100, 1000, 1000, 0, 500);
    seg(1000);
    seg(900);
    end_phase("saturation");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
